// File: rtl/sound_pkg.sv
// Shared types and constants for the game sound path.
// Mixer mode encoding and volume range used by the mixer and its DAC.
package sound_pkg;

  typedef enum logic {
    MIX_XOR = 1'b0,
    MIX_PDM = 1'b1
  } mix_mode_e;

  localparam int VOL_W   = 4;
  localparam int VOL_MAX = 15;

  // Full-scale level: every channel high at maximum volume.
  function automatic int full_scale(input int n_ch);
    return n_ch * VOL_MAX;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: turns a level in 0..FS into a 1-bit
// pulse stream whose density is level/FS. clr restarts from an empty accumulator.
module sigma_delta_dac #(
  parameter int LEVEL_W = 7,
  parameter int FS      = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [LEVEL_W-1:0] level,
  output logic               pdm_out
);

  // acc stays below FS, so acc + level never reaches 2*FS.
  localparam int ACC_W = $clog2(2 * FS);
  localparam logic [ACC_W-1:0] FS_A = ACC_W'(FS);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // NOTE: combinational logic assigns every output on every path, so no latch is inferred.
  always_comb begin
    sum = acc + ACC_W'(level);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else if (sum >= FS_A) begin
      acc     <= sum - FS_A;
      pdm_out <= 1'b1;
    end else begin
      acc     <= sum;
      pdm_out <= 1'b0;
    end
  end

endmodule

// File: rtl/pdm_sound_mixer.sv
// N-channel mixer merging melody_gen square waves into one speaker bit,
// either as a legacy XOR of the channels or as a volume-weighted PDM stream.
module pdm_sound_mixer
  import sound_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int SAMPLE_DIV = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           ch_wave,
  input  logic [N_CH-1:0]           ch_off,
  input  logic                      mode,
  input  logic [VOL_W-1:0]          volume,
  output logic                      mix_out,
  output logic [$clog2(N_CH+1)-1:0] active_cnt,
  output logic                      sample_tick
);

  localparam int CNT_W   = $clog2(N_CH + 1);
  localparam int FS      = full_scale(N_CH);
  localparam int LEVEL_W = $clog2(FS + 1);
  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [N_CH-1:0]    wave_q;
  mix_mode_e          mode_q;
  mix_mode_e          mode_prev;
  logic [VOL_W-1:0]   vol_q;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [LEVEL_W-1:0] level;
  logic               xor_q;
  logic               xor_mix;
  logic               pdm_out;
  logic               mode_chg;
  logic               dac_clr;

  // Stage 1: capture the unmuted channels and the controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wave_q    <= '0;
      mode_q    <= MIX_XOR;
      mode_prev <= MIX_XOR;
      vol_q     <= '0;
    end else begin
      wave_q    <= ch_wave & ~ch_off;
      mode_q    <= mix_mode_e'(mode);
      mode_prev <= mode_q;
      vol_q     <= volume;
    end
  end

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      sample_tick <= tick;
    end
  end

  // Stage 2: the level is resampled only on ticks and held in between.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_cnt <= '0;
      level      <= '0;
      xor_q      <= 1'b0;
    end else if (tick) begin
      active_cnt <= popcount(wave_q);
      level      <= LEVEL_W'(popcount(wave_q)) * LEVEL_W'(vol_q);
      xor_q      <= ^wave_q;
    end
  end

  // Stage 3: a mode change silences the output for one cycle and empties the DAC.
  assign mode_chg = (mode_q != mode_prev);
  assign dac_clr  = mode_chg || (mode_q == MIX_XOR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xor_mix <= 1'b0;
    end else begin
      xor_mix <= !mode_chg && (mode_q == MIX_XOR) && xor_q;
    end
  end

  sigma_delta_dac #(
    .LEVEL_W (LEVEL_W),
    .FS      (FS)
  ) u_dac (
    .clk     (clk),
    .reset   (reset),
    .clr     (dac_clr),
    .level   (level),
    .pdm_out (pdm_out)
  );

  // At most one of the two registered paths can be high in any cycle.
  assign mix_out = pdm_out | xor_mix;

endmodule

// File: tb/tb_pdm_sound_mixer.sv
// Bench for pdm_sound_mixer: two instances (SAMPLE_DIV 1 and 4) share stimulus
// and are compared every cycle against an integral-based reference model.
module tb_pdm_sound_mixer;

  localparam int N_CH = 8;
  localparam int FS   = N_CH * 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ch_wave = '0;
  logic [7:0] ch_off = '0;
  logic       mode = 1'b0;
  logic [3:0] volume = '0;

  logic       mix_out_a, mix_out_b;
  logic [3:0] active_cnt_a, active_cnt_b;
  logic       sample_tick_a, sample_tick_b;

  pdm_sound_mixer #(.N_CH(N_CH), .SAMPLE_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .ch_wave(ch_wave), .ch_off(ch_off), .mode(mode),
    .volume(volume), .mix_out(mix_out_a), .active_cnt(active_cnt_a), .sample_tick(sample_tick_a)
  );

  pdm_sound_mixer #(.N_CH(N_CH), .SAMPLE_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .ch_wave(ch_wave), .ch_off(ch_off), .mode(mode),
    .volume(volume), .mix_out(mix_out_b), .active_cnt(active_cnt_b), .sample_tick(sample_tick_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: hist[j] holds the inputs seen at edge j since reset (hist[0] = reset state).
  // The PDM output is the number of full-scale crossings of the running integral of the level.
  typedef struct packed {
    logic [7:0] eff;
    logic       mode;
    logic [3:0] vol;
  } smp_t;

  smp_t   hist[$];
  int     k;
  int     div_of [2] = '{1, 4};
  int     cnt_e [2];
  int     lvl_e [2];
  int     xor_e [2];
  int     out_e [2];
  int     tick_e [2];
  longint integ [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist.delete();
      hist.push_back('0);
      k = 0;
      for (int i = 0; i < 2; i++) begin
        cnt_e[i] = 0; lvl_e[i] = 0; xor_e[i] = 0; out_e[i] = 0; tick_e[i] = 0; integ[i] = 0;
      end
    end else begin
      smp_t   cur;
      bit     m_now;
      bit     m_prev;
      longint ns;
      k++;
      cur    = hist[k-1];
      m_now  = cur.mode;
      m_prev = (k >= 2) ? hist[k-2].mode : 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_now != m_prev) begin
          out_e[i] = 0;
          integ[i] = 0;
        end else if (!m_now) begin
          out_e[i] = xor_e[i];
          integ[i] = 0;
        end else begin
          ns       = integ[i] + lvl_e[i];
          out_e[i] = int'(ns / FS - integ[i] / FS);
          integ[i] = ns;
        end
        tick_e[i] = (k % div_of[i] == 0) ? 1 : 0;
        if (tick_e[i] != 0) begin
          cnt_e[i] = $countones(cur.eff);
          lvl_e[i] = cnt_e[i] * int'(cur.vol);
          xor_e[i] = cnt_e[i] % 2;
        end
      end
      hist.push_back('{eff: ch_wave & ~ch_off, mode: mode, vol: volume});
    end
  end

  always @(negedge clk) begin
    check("mix_a",  mix_out_a,     out_e[0]);
    check("cnt_a",  active_cnt_a,  cnt_e[0]);
    check("tick_a", sample_tick_a, tick_e[0]);
    check("mix_b",  mix_out_b,     out_e[1]);
    check("cnt_b",  active_cnt_b,  cnt_e[1]);
    check("tick_b", sample_tick_b, tick_e[1]);
  end

  task automatic drive(input logic [7:0] w, input logic [7:0] o, input logic m, input logic [3:0] v);
    ch_wave = w; ch_off = o; mode = m; volume = v;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += int'(mix_out_a);
    end
  endtask

  int ones;
  int ticks;
  bit found;

  initial begin
    // Reset held with all channels high in PDM mode at full volume.
    drive(8'hFF, 8'h00, 1'b1, 4'd15);
    repeat (3) @(negedge clk);
    check("rst_mix", mix_out_a, 0);
    check("rst_cnt", active_cnt_a, 0);
    check("rst_tick", sample_tick_a, 0);
    #2 reset = 1'b1;
    @(negedge clk) check("edge1", mix_out_a, 0);
    @(negedge clk) check("edge2", mix_out_a, 0);
    @(negedge clk) check("edge3", mix_out_a, 1);

    // Legacy XOR mode.
    drive(8'b0000_0111, 8'h00, 1'b0, 4'd15);
    repeat (5) @(negedge clk);
    check("xor_on", mix_out_a, 1);
    ch_off = 8'h01;
    repeat (4) @(negedge clk);
    check("xor_off", mix_out_a, 0);

    // PDM densities: half scale, full scale, zero volume, all muted.
    drive(8'h0F, 8'h00, 1'b1, 4'd15);
    repeat (6) @(negedge clk);
    count_ones(120, ones);
    check("dens_half", ones, 60);
    drive(8'hFF, 8'h00, 1'b1, 4'd15);
    repeat (5) @(negedge clk);
    count_ones(120, ones);
    check("dens_full", ones, 120);
    volume = 4'd0;
    repeat (5) @(negedge clk);
    count_ones(60, ones);
    check("dens_vol0", ones, 0);
    drive(8'hFF, 8'hFF, 1'b1, 4'd15);
    repeat (5) @(negedge clk);
    count_ones(60, ones);
    check("dens_muted", ones, 0);

    // Decimation: tick rate and a short pulse between ticks.
    drive(8'h0F, 8'h00, 1'b1, 4'd15);
    repeat (8) @(negedge clk);
    ticks = 0;
    repeat (40) begin
      @(negedge clk);
      ticks += int'(sample_tick_b);
    end
    check("tick_rate_b", ticks, 10);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      found = sample_tick_b;
    end
    check("tick_found_b", found, 1);
    ch_wave = 8'hFF;
    repeat (2) @(negedge clk);
    ch_wave = 8'h0F;
    repeat (2) @(negedge clk);
    check("pulse_tick_b", sample_tick_b, 1);
    check("pulse_cnt_b", active_cnt_b, $countones(8'h0F));

    // Mode switch mid-stream from a constant-1 PDM stream.
    drive(8'hFF, 8'h00, 1'b1, 4'd15);
    repeat (6) @(negedge clk);
    check("pre_switch", mix_out_a, 1);
    mode = 1'b0;
    @(negedge clk);
    @(negedge clk) check("switch_clr", mix_out_a, 0);
    mode = 1'b1;
    repeat (6) @(negedge clk);

    // Reset pulse mid-stream: output drops without waiting for a clock edge.
    check("pre_reset", mix_out_a, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_a", mix_out_a, 0);
    check("async_rst_b", mix_out_b, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    ch_wave = 8'b1010_1000;
    repeat (6) @(negedge clk);
    count_ones(120, ones);
    check("dens_45", ones, 45);

    // Randomized traffic, including mode flips, mutes and decimation aliasing.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) ch_wave = 8'($urandom);
      if ($urandom_range(15) == 0) ch_off = 8'($urandom) & 8'($urandom);
      if ($urandom_range(15) == 0) volume = 4'($urandom);
      if ($urandom_range(30) == 0) mode = ~mode;
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
